// File: rtl/dcache_pkg.sv
// Shared types and constants for the L1D refill / uncached-read responder.
// Also provides the IO load alignment helper.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV,
        S_RF_REQ,
        S_RF_DATA,
        S_VALIDATE,
        S_IO_REQ,
        S_IO_DATA,
        S_CMP
    } state_e;

    localparam logic [1:0] OP_B = 2'b00;
    localparam logic [1:0] OP_H = 2'b01;
    localparam logic [1:0] OP_W = 2'b10;

    localparam int unsigned LINE_WORDS = 32;
    localparam int unsigned SETS       = 64;

    localparam int unsigned IO_BIT  = 31;
    localparam int unsigned SET_LSB = 7;
    localparam int unsigned SET_MSB = 12;
    localparam int unsigned TAG_LSB = 13;
    localparam int unsigned TAG_MSB = 30;

    // Right-justify the addressed lane of a bus-aligned word; upper bits zero.
    function automatic logic [31:0] io_align(input logic [31:0] data,
                                             input logic [1:0]  lo,
                                             input logic [1:0]  op);
        logic [31:0] sh;
        sh = '0;
        case (op)
            OP_B: begin
                sh = data >> {lo, 3'b000};
                return {24'b0, sh[7:0]};
            end
            OP_H: begin
                sh = lo[1] ? (data >> 16) : data;
                return {16'b0, sh[15:0]};
            end
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/dcache_refill_unit.sv
// Miss/IO responder for the load queue: refills a 32-word line into the 2-way
// data array and installs its tag, or performs one uncached bus read.
module dcache_refill_unit
    import dcache_pkg::*;
(
    input  logic        cpu_clock_i,
    input  logic        cpu_resetn_i,

    input  logic        dc_req,
    input  logic [31:0] dc_addr,
    input  logic [1:0]  dc_op,
    output logic [31:0] dc_data,
    output logic        dc_cmp,

    output logic        bram_wr_en_o,
    output logic [11:0] bram_wr_addr_o,
    output logic [31:0] bram_wr_data_o,

    output logic        tag_wr_en_o,
    output logic [5:0]  tag_wr_set_o,
    output logic        tag_wr_way_o,
    output logic [17:0] tag_wr_tag_o,
    output logic        tag_wr_valid_o,

    output logic        mem_rd_vld_o,
    input  logic        mem_rd_rdy_i,
    output logic [31:0] mem_rd_addr_o,
    output logic        mem_rd_burst_o,
    output logic [1:0]  mem_rd_size_o,
    input  logic        mem_rsp_vld_i,
    input  logic [31:0] mem_rsp_data_i
);

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [1:0]      op_q, op_d;
    logic            way_q, way_d;
    logic [4:0]      beat_q, beat_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [SETS-1:0] victim_q, victim_d;

    logic [5:0]      set_idx;
    logic [17:0]     tag_idx;

    assign set_idx = addr_q[SET_MSB:SET_LSB];
    assign tag_idx = addr_q[TAG_MSB:TAG_LSB];
    assign dc_data = rdata_q;

    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            op_q     <= '0;
            way_q    <= 1'b0;
            beat_q   <= '0;
            rdata_q  <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            way_q    <= way_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        op_d           = op_q;
        way_d          = way_q;
        beat_d         = beat_q;
        rdata_d        = rdata_q;
        victim_d       = victim_q;

        dc_cmp         = 1'b0;
        bram_wr_en_o   = 1'b0;
        bram_wr_addr_o = '0;
        bram_wr_data_o = '0;
        tag_wr_en_o    = 1'b0;
        tag_wr_set_o   = '0;
        tag_wr_way_o   = 1'b0;
        tag_wr_tag_o   = '0;
        tag_wr_valid_o = 1'b0;
        mem_rd_vld_o   = 1'b0;
        mem_rd_addr_o  = '0;
        mem_rd_burst_o = 1'b0;
        mem_rd_size_o  = '0;

        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (dc_req) begin
                    // The victim way is chosen here so INV and the refill agree.
                    addr_d  = dc_addr;
                    op_d    = dc_op;
                    way_d   = victim_q[dc_addr[SET_MSB:SET_LSB]];
                    state_d = dc_addr[IO_BIT] ? S_IO_REQ : S_INV;
                end
            end

            S_INV: begin
                tag_wr_en_o    = 1'b1;
                tag_wr_set_o   = set_idx;
                tag_wr_way_o   = way_q;
                tag_wr_tag_o   = tag_idx;
                tag_wr_valid_o = 1'b0;
                state_d        = S_RF_REQ;
            end

            S_RF_REQ: begin
                mem_rd_vld_o   = 1'b1;
                mem_rd_burst_o = 1'b1;
                mem_rd_addr_o  = {addr_q[31:7], 7'b0};
                if (mem_rd_rdy_i) begin
                    state_d = S_RF_DATA;
                end
            end

            S_RF_DATA: begin
                if (mem_rsp_vld_i) begin
                    bram_wr_en_o   = 1'b1;
                    bram_wr_addr_o = {way_q, set_idx, beat_q};
                    bram_wr_data_o = mem_rsp_data_i;
                    beat_d         = beat_q + 5'd1;
                    if (beat_q == 5'(LINE_WORDS - 1)) begin
                        state_d = S_VALIDATE;
                    end
                end
            end

            S_VALIDATE: begin
                tag_wr_en_o       = 1'b1;
                tag_wr_set_o      = set_idx;
                tag_wr_way_o      = way_q;
                tag_wr_tag_o      = tag_idx;
                tag_wr_valid_o    = 1'b1;
                victim_d[set_idx] = ~victim_q[set_idx];
                state_d           = S_CMP;
            end

            S_IO_REQ: begin
                mem_rd_vld_o   = 1'b1;
                mem_rd_addr_o  = addr_q;
                mem_rd_size_o  = op_q;
                if (mem_rd_rdy_i) begin
                    state_d = S_IO_DATA;
                end
            end

            S_IO_DATA: begin
                if (mem_rsp_vld_i) begin
                    rdata_d = io_align(mem_rsp_data_i, addr_q[1:0], op_q);
                    state_d = S_CMP;
                end
            end

            S_CMP: begin
                dc_cmp  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // A response beat before the burst request is accepted is a bus protocol error.
    rsp_before_grant_a: assert property (
        @(posedge cpu_clock_i) disable iff (!cpu_resetn_i)
        !(state_q == S_RF_REQ && mem_rsp_vld_i)
    );

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed and randomized requests against a transaction-level model of the
// refill unit: victim bits per set, expected bus requests, writes and latency.
module tb_dcache_refill_unit;

    logic        clk;
    logic        cpu_resetn_i;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic [1:0]  dc_op;
    logic [31:0] dc_data;
    logic        dc_cmp;
    logic        bram_wr_en_o;
    logic [11:0] bram_wr_addr_o;
    logic [31:0] bram_wr_data_o;
    logic        tag_wr_en_o;
    logic [5:0]  tag_wr_set_o;
    logic        tag_wr_way_o;
    logic [17:0] tag_wr_tag_o;
    logic        tag_wr_valid_o;
    logic        mem_rd_vld_o;
    logic        mem_rd_rdy_i;
    logic [31:0] mem_rd_addr_o;
    logic        mem_rd_burst_o;
    logic [1:0]  mem_rd_size_o;
    logic        mem_rsp_vld_i;
    logic [31:0] mem_rsp_data_i;

    dcache_refill_unit dut (
        .cpu_clock_i    (clk),
        .cpu_resetn_i   (cpu_resetn_i),
        .dc_req         (dc_req),
        .dc_addr        (dc_addr),
        .dc_op          (dc_op),
        .dc_data        (dc_data),
        .dc_cmp         (dc_cmp),
        .bram_wr_en_o   (bram_wr_en_o),
        .bram_wr_addr_o (bram_wr_addr_o),
        .bram_wr_data_o (bram_wr_data_o),
        .tag_wr_en_o    (tag_wr_en_o),
        .tag_wr_set_o   (tag_wr_set_o),
        .tag_wr_way_o   (tag_wr_way_o),
        .tag_wr_tag_o   (tag_wr_tag_o),
        .tag_wr_valid_o (tag_wr_valid_o),
        .mem_rd_vld_o   (mem_rd_vld_o),
        .mem_rd_rdy_i   (mem_rd_rdy_i),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_rd_burst_o (mem_rd_burst_o),
        .mem_rd_size_o  (mem_rd_size_o),
        .mem_rsp_vld_i  (mem_rsp_vld_i),
        .mem_rsp_data_i (mem_rsp_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    bit          victim [64];
    logic [31:0] last_io;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [31:0] a,
                                              input logic [1:0] op);
        int unsigned v;
        int unsigned lane;
        v = d;
        if (op == 2'd0) begin
            lane = a % 4;
            return (v >> (8 * lane)) % 256;
        end else if (op == 2'd1) begin
            lane = (a / 2) % 2;
            return (v >> (16 * lane)) % 65536;
        end
        return v;
    endfunction

    task automatic all_zero(input string tag);
        chk(tag, {dc_data, dc_cmp, bram_wr_en_o, bram_wr_addr_o, bram_wr_data_o,
                  tag_wr_en_o, tag_wr_set_o, tag_wr_way_o, tag_wr_tag_o, tag_wr_valid_o,
                  mem_rd_vld_o, mem_rd_addr_o, mem_rd_burst_o, mem_rd_size_o}, '0);
    endtask

    // One load-queue request with a memory model; rst_beat >= 0 asserts reset before that beat.
    task automatic run_req(input logic [31:0] a, input logic [1:0] op, input int rdy_wait,
                           input int gap, input int rst_beat, input logic [31:0] io_word);
        bit          is_io;
        logic [5:0]  set;
        logic [17:0] tg;
        bit          way;
        int          nbeats;
        logic [31:0] beat [32];
        logic [31:0] exp_addr;
        logic [7:0]  tag_q [$];
        logic [17:0] tagv_q [$];
        int          tagc_q [$];
        logic [43:0] bram_q [$];
        int          cyc, wait_cnt, beats_sent, gap_cnt, hs_cnt, cmp_cnt, cmp_cyc, exp_lat;
        bit          hs_pending, hs_done, done, activity;
        logic [31:0] cmp_data;

        is_io    = a[31];
        set      = a[12:7];
        tg       = a[30:13];
        way      = victim[set];
        nbeats   = is_io ? 1 : 32;
        exp_addr = is_io ? a : ((a / 128) * 128);
        for (int i = 0; i < 32; i++) beat[i] = $urandom;
        if (is_io) beat[0] = io_word;

        cyc = 0; wait_cnt = 0; beats_sent = 0; gap_cnt = 0; hs_cnt = 0; cmp_cnt = 0;
        cmp_cyc = -1; hs_pending = 0; hs_done = 0; done = 0; cmp_data = '0;

        while (!done && cyc < 2000) begin
            @(negedge clk);
            if (hs_pending) begin
                hs_done    = 1;
                hs_pending = 0;
            end
            if (rst_beat >= 0 && hs_done && beats_sent == rst_beat && gap_cnt == 0) begin
                cpu_resetn_i  = 1'b0;
                dc_req        = 1'b0;
                mem_rsp_vld_i = 1'b0;
                mem_rd_rdy_i  = 1'b0;
                #1;
                all_zero("reset_mid_op");
                repeat (2) @(negedge clk);
                cpu_resetn_i = 1'b1;
                for (int i = 0; i < 64; i++) victim[i] = 0;
                last_io = '0;
                return;
            end
            dc_req = 1'b1;
            if (cyc == 0) begin
                dc_addr = a;
                dc_op   = op;
            end else begin
                dc_addr = $urandom;
                dc_op   = 2'($urandom_range(0, 3));
            end
            mem_rd_rdy_i = (wait_cnt >= rdy_wait);
            if (hs_done && beats_sent < nbeats && gap_cnt == 0) begin
                mem_rsp_vld_i  = 1'b1;
                mem_rsp_data_i = beat[beats_sent];
                beats_sent++;
                gap_cnt = gap;
            end else begin
                mem_rsp_vld_i  = 1'b0;
                mem_rsp_data_i = $urandom;
                if (gap_cnt > 0) gap_cnt--;
            end
            #1;
            if (mem_rd_vld_o) begin
                chk("mem_rd_addr", mem_rd_addr_o, exp_addr);
                chk("mem_rd_burst", mem_rd_burst_o, !is_io);
                chk("mem_rd_size", mem_rd_size_o, is_io ? op : 2'b00);
                if (mem_rd_rdy_i) begin
                    hs_cnt++;
                    hs_pending = 1;
                end else begin
                    wait_cnt++;
                end
            end
            if (tag_wr_en_o) begin
                tag_q.push_back({tag_wr_set_o, tag_wr_way_o, tag_wr_valid_o});
                tagv_q.push_back(tag_wr_tag_o);
                tagc_q.push_back(cyc);
            end
            if (bram_wr_en_o) bram_q.push_back({bram_wr_addr_o, bram_wr_data_o});
            if (dc_cmp) begin
                cmp_cnt++;
                cmp_cyc  = cyc;
                cmp_data = dc_data;
                done     = 1;
            end
            cyc++;
        end

        exp_lat = is_io ? (3 + rdy_wait) : (36 + rdy_wait + 31 * gap);
        chk("cmp_seen", cmp_cnt, 1);
        chk("cmp_latency", cmp_cyc, exp_lat);
        chk("mem_handshakes", hs_cnt, 1);
        chk("tag_write_count", tag_q.size(), is_io ? 0 : 2);
        chk("bram_write_count", bram_q.size(), is_io ? 0 : 32);
        if (!is_io && tag_q.size() == 2) begin
            chk("tag_inv", {tag_q[0], 32'(tagc_q[0])}, {set, way, 1'b0, 32'd1});
            chk("tag_validate", {tag_q[1], tagv_q[1], 32'(tagc_q[1])},
                {set, way, 1'b1, tg, 32'(cmp_cyc - 1)});
        end
        for (int k = 0; k < bram_q.size() && k < 32; k++) begin
            chk("bram_write", bram_q[k], {way, set, 5'(k), beat[k]});
        end
        if (is_io) begin
            last_io = ref_align(io_word, a, op);
        end else begin
            victim[set] = ~victim[set];
        end
        chk("dc_data_at_cmp", cmp_data, last_io);

        activity = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            dc_req        = 1'b0;
            dc_addr       = $urandom;
            mem_rsp_vld_i = 1'b0;
            #1;
            activity = activity | dc_cmp | tag_wr_en_o | bram_wr_en_o | mem_rd_vld_o;
        end
        chk("idle_after_cmp", activity, 1'b0);
        chk("dc_data_hold", dc_data, last_io);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rop;

        cpu_resetn_i   = 1'b0;
        dc_req         = 1'b0;
        dc_addr        = '0;
        dc_op          = '0;
        mem_rd_rdy_i   = 1'b0;
        mem_rsp_vld_i  = 1'b0;
        mem_rsp_data_i = '0;
        last_io        = '0;
        for (int i = 0; i < 64; i++) victim[i] = 0;

        repeat (3) @(negedge clk);
        #1;
        all_zero("reset_state");
        cpu_resetn_i = 1'b1;

        run_req(32'h8000_0003, 2'b00, 0, 0, -1, 32'hAB00_0000);
        run_req(32'h8000_0002, 2'b01, 0, 0, -1, 32'h1234_5678);
        run_req(32'h8000_0010, 2'b10, 2, 0, -1, 32'hDEAD_BEEF);
        run_req(32'h8000_0001, 2'b00, 1, 0, -1, 32'h00C3_5A00);
        run_req(32'h0000_1234, 2'b10, 0, 0, -1, '0);
        run_req(32'h0000_3234, 2'b01, 0, 0, -1, '0);
        run_req(32'h0000_5234, 2'b00, 5, 3, -1, '0);
        run_req(32'h0000_7A80, 2'b10, 1, 0, 10, '0);
        run_req(32'h0000_1234, 2'b10, 0, 0, -1, '0);
        run_req(32'h8000_0006, 2'b01, 0, 0, -1, 32'hFEDC_BA98);

        for (int n = 0; n < 14; n++) begin
            ra = $urandom;
            ra[12:7] = 6'(32 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                ra[31] = 1'b1;
                rop    = 2'($urandom_range(0, 2));
            end else begin
                ra[31] = 1'b0;
                rop    = 2'($urandom_range(0, 3));
            end
            run_req(ra, rop, $urandom_range(0, 3), $urandom_range(0, 2), -1, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
